// File: rtl/rx_frame_capture_if.sv
// Bundle of the receive-side byte stream, the FIFO output stream and the
// frame statistics of rx_frame_capture. Signal prefixes are from the
// capture block's point of view (i_ = into the block, o_ = out of it).
interface rx_frame_capture_if;
  logic [7:0]  i_rxd;
  logic        i_rx_dv;
  logic [7:0]  o_out_data;
  logic        o_out_last;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [10:0] o_frame_len;
  logic        o_len_valid;
  logic [7:0]  o_frame_cnt;
  logic [7:0]  o_err_cnt;
  logic        o_overflow;

  // Capture block side
  modport slave (
    input  i_rxd, i_rx_dv, i_out_ready,
    output o_out_data, o_out_last, o_out_valid,
           o_frame_len, o_len_valid, o_frame_cnt, o_err_cnt, o_overflow
  );

  // Environment side: PCS source, downstream sink and statistics reader
  modport master (
    output i_rxd, i_rx_dv, i_out_ready,
    input  o_out_data, o_out_last, o_out_valid,
           o_frame_len, o_len_valid, o_frame_cnt, o_err_cnt, o_overflow
  );
endinterface

// File: rtl/rx_frame_capture.sv
// Receive frame capture: strips preamble/SFD from a PCS byte stream, pushes
// the payload into a first-word-fall-through FIFO with an end-of-frame flag,
// and keeps good/errored frame statistics.
// Payload bytes pass through a one-byte staging register so the final byte
// can be tagged LAST when RX_DV falls, without needing lookahead.
module rx_frame_capture #(
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_LEN    = 1518
) (
  input logic             clk,
  input logic             rst_n,
  rx_frame_capture_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] LP_ST_IDLE     = 2'd0;
  localparam logic [1:0] LP_ST_PREAMBLE = 2'd1;
  localparam logic [1:0] LP_ST_DATA     = 2'd2;
  localparam logic [1:0] LP_ST_DROP     = 2'd3;

  localparam logic [10:0] LP_MAX_LEN = 11'(MAX_LEN);
  localparam logic [AW:0] LP_PTR_ONE = (AW+1)'(1);

  // Saturating increment for the 8-bit frame statistics
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'h01;
    end
  endfunction

  // FSM / staging state
  logic [1:0]  r_state;
  logic [7:0]  r_stage_data;
  logic        r_stage_vld;
  logic [10:0] r_byte_cnt;
  logic        r_frame_err;

  // Statistics
  logic [10:0] r_frame_len;
  logic        r_len_valid;
  logic [7:0]  r_frame_cnt;
  logic [7:0]  r_err_cnt;
  logic        r_overflow;

  // FIFO storage and pointers (extra MSB separates full from empty)
  logic [8:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;

  logic [1:0]  w_state_nxt;
  logic        w_stage_ld;
  logic        w_clr_frame;
  logic        w_wr_en;
  logic        w_wr_last;
  logic        w_err_inc;
  logic        w_good_end;
  logic        w_full;
  logic        w_empty;
  logic        w_wr_ok;
  logic        w_wr_drop;
  logic        w_rd_en;
  logic [8:0]  w_head;

  // FIFO status comes from registered pointers only, so fullness is judged
  // before any read happening in the same cycle.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_wr_ok   = w_wr_en & ~w_full;
  assign w_wr_drop = w_wr_en & w_full;
  assign w_rd_en   = ~w_empty & bus.i_out_ready;
  assign w_head    = r_mem[r_rd_ptr[AW-1:0]];

  // Frame parser: next state, staging load, FIFO write and statistic events
  always_comb begin
    w_state_nxt = r_state;
    w_stage_ld  = 1'b0;
    w_clr_frame = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_last   = 1'b0;
    w_err_inc   = 1'b0;
    w_good_end  = 1'b0;
    case (r_state)
      LP_ST_IDLE: begin
        if (bus.i_rx_dv) begin
          if (bus.i_rxd == 8'h55) begin
            w_state_nxt = LP_ST_PREAMBLE;
          end else begin
            w_state_nxt = LP_ST_DROP;
            w_err_inc   = 1'b1;
          end
        end else begin
          w_state_nxt = LP_ST_IDLE;
        end
      end
      LP_ST_PREAMBLE: begin
        if (!bus.i_rx_dv) begin
          w_state_nxt = LP_ST_IDLE;
          w_err_inc   = 1'b1;
        end else if (bus.i_rxd == 8'h55) begin
          w_state_nxt = LP_ST_PREAMBLE;
        end else if (bus.i_rxd == 8'hD5) begin
          w_state_nxt = LP_ST_DATA;
          w_clr_frame = 1'b1;
        end else begin
          w_state_nxt = LP_ST_DROP;
          w_err_inc   = 1'b1;
        end
      end
      LP_ST_DATA: begin
        if (bus.i_rx_dv) begin
          if (r_byte_cnt == LP_MAX_LEN) begin
            // Oversize: close the frame on the staged byte, discard the rest
            w_wr_en     = r_stage_vld;
            w_wr_last   = 1'b1;
            w_err_inc   = 1'b1;
            w_state_nxt = LP_ST_DROP;
          end else begin
            w_wr_en    = r_stage_vld;
            w_stage_ld = 1'b1;
          end
        end else begin
          w_state_nxt = LP_ST_IDLE;
          if (r_stage_vld) begin
            w_wr_en   = 1'b1;
            w_wr_last = 1'b1;
            if (r_frame_err || w_full) begin
              w_err_inc = 1'b1;
            end else begin
              w_good_end = 1'b1;
            end
          end else begin
            w_err_inc = 1'b1;
          end
        end
      end
      LP_ST_DROP: begin
        if (bus.i_rx_dv) begin
          w_state_nxt = LP_ST_DROP;
        end else begin
          w_state_nxt = LP_ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = LP_ST_IDLE;
      end
    endcase
  end

  // FSM state, staging register, byte count and per-frame overflow marker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= LP_ST_IDLE;
      r_stage_data <= 8'h00;
      r_stage_vld  <= 1'b0;
      r_byte_cnt   <= 11'd0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clr_frame) begin
        r_stage_vld <= 1'b0;
        r_byte_cnt  <= 11'd0;
        r_frame_err <= 1'b0;
      end else if (w_stage_ld) begin
        r_stage_data <= bus.i_rxd;
        r_stage_vld  <= 1'b1;
        r_byte_cnt   <= r_byte_cnt + 11'd1;
      end else if ((r_state == LP_ST_DATA) && (w_state_nxt != LP_ST_DATA)) begin
        r_stage_vld <= 1'b0;
      end
      if (w_wr_drop) begin
        r_frame_err <= 1'b1;
      end
    end
  end

  // Frame statistics and sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_len <= 11'd0;
      r_len_valid <= 1'b0;
      r_frame_cnt <= 8'h00;
      r_err_cnt   <= 8'h00;
      r_overflow  <= 1'b0;
    end else begin
      r_len_valid <= w_good_end;
      if (w_good_end) begin
        r_frame_len <= r_byte_cnt;
        r_frame_cnt <= sat_inc(r_frame_cnt);
      end
      if (w_err_inc) begin
        r_err_cnt <= sat_inc(r_err_cnt);
      end
      if (w_wr_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // FIFO pointers: advance on accepted write and on downstream transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
      end
    end
  end

  // FIFO storage write of {last, data}; contents are qualified by the pointers
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {w_wr_last, r_stage_data};
    end
  end

  // Head of FIFO is forced to zero while empty so reset/idle values are defined
  assign bus.o_out_valid = ~w_empty;
  assign bus.o_out_data  = w_empty ? 8'h00 : w_head[7:0];
  assign bus.o_out_last  = w_empty ? 1'b0  : w_head[8];
  assign bus.o_frame_len = r_frame_len;
  assign bus.o_len_valid = r_len_valid;
  assign bus.o_frame_cnt = r_frame_cnt;
  assign bus.o_err_cnt   = r_err_cnt;
  assign bus.o_overflow  = r_overflow;

endmodule

// File: tb/tb_rx_frame_capture.sv
// Directed testbench for rx_frame_capture. Two instances share one stimulus
// stream: bus_a uses default parameters, bus_b uses MAX_LEN=8 for the
// oversize scenario. Output transfers and LEN_VALID pulses are logged by
// negedge monitors; each test compares against hand-computed values.
module tb_rx_frame_capture;

  logic       clk;
  logic       rst_n;
  logic [7:0] tb_rxd;
  logic       tb_rx_dv;
  logic       tb_ready;

  int checks;
  int failures;

  rx_frame_capture_if bus_a ();
  rx_frame_capture_if bus_b ();

  assign bus_a.i_rxd       = tb_rxd;
  assign bus_a.i_rx_dv     = tb_rx_dv;
  assign bus_a.i_out_ready = tb_ready;
  assign bus_b.i_rxd       = tb_rxd;
  assign bus_b.i_rx_dv     = tb_rx_dv;
  assign bus_b.i_out_ready = tb_ready;

  rx_frame_capture #(.FIFO_DEPTH(16), .MAX_LEN(1518)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  rx_frame_capture #(.FIFO_DEPTH(16), .MAX_LEN(8)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transfer / LEN_VALID logs, written only by the monitors
  logic [8:0] mon_a [1024];
  logic [8:0] mon_b [1024];
  int         mon_a_n = 0;
  int         mon_b_n = 0;
  int         len_a_n = 0;
  int         len_b_n = 0;
  logic [10:0] last_len_a = 11'd0;

  // Record transfers (valid & ready) and length pulses between edges
  always @(negedge clk) begin
    if (rst_n && bus_a.o_out_valid && tb_ready) begin
      if (mon_a_n < 1024) mon_a[mon_a_n] <= {bus_a.o_out_last, bus_a.o_out_data};
      mon_a_n <= mon_a_n + 1;
    end
    if (rst_n && bus_b.o_out_valid && tb_ready) begin
      if (mon_b_n < 1024) mon_b[mon_b_n] <= {bus_b.o_out_last, bus_b.o_out_data};
      mon_b_n <= mon_b_n + 1;
    end
    if (rst_n && bus_a.o_len_valid) begin
      len_a_n    <= len_a_n + 1;
      last_len_a <= bus_a.o_frame_len;
    end
    if (rst_n && bus_b.o_len_valid) begin
      len_b_n <= len_b_n + 1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    tb_rxd   = b;
    tb_rx_dv = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic end_frame();
    tb_rxd   = 8'h00;
    tb_rx_dv = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_preamble(input int n55);
    for (int i = 0; i < n55; i++) send_byte(8'h55);
    send_byte(8'hD5);
  endtask

  task automatic do_reset();
    tb_rxd   = 8'h00;
    tb_rx_dv = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tb_ready = 1'b1;
    tb_rxd   = 8'h00;
    tb_rx_dv = 1'b0;
    rst_n    = 1'b0;
    #1;
    checks++; if (bus_a.o_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0h expected 0", bus_a.o_out_valid); end
    checks++; if (bus_a.o_out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data: got %0h expected 0", bus_a.o_out_data); end
    checks++; if (bus_a.o_out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last: got %0h expected 0", bus_a.o_out_last); end
    checks++; if (bus_a.o_frame_len !== 11'd0) begin failures++; $display("FAIL reset_frame_len: got %0h expected 0", bus_a.o_frame_len); end
    checks++; if (bus_a.o_len_valid !== 1'b0) begin failures++; $display("FAIL reset_len_valid: got %0h expected 0", bus_a.o_len_valid); end
    checks++; if (bus_a.o_frame_cnt !== 8'h00) begin failures++; $display("FAIL reset_frame_cnt: got %0h expected 0", bus_a.o_frame_cnt); end
    checks++; if (bus_a.o_err_cnt !== 8'h00) begin failures++; $display("FAIL reset_err_cnt: got %0h expected 0", bus_a.o_err_cnt); end
    checks++; if (bus_a.o_overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %0h expected 0", bus_a.o_overflow); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_good_frame();
    int base;
    int lbase;
    logic [8:0] exp;
    do_reset();
    tb_ready = 1'b1;
    base  = mon_a_n;
    lbase = len_a_n;
    send_preamble(7);
    send_byte(8'h01);
    checks++; if (bus_a.o_out_valid !== 1'b0) begin failures++; $display("FAIL good_latency_n1: got %0h expected 0", bus_a.o_out_valid); end
    send_byte(8'h02);
    checks++; if ({bus_a.o_out_valid, bus_a.o_out_data} !== 9'h101) begin failures++; $display("FAIL good_latency_n2: got %0h expected 101", {bus_a.o_out_valid, bus_a.o_out_data}); end
    send_byte(8'h03);
    send_byte(8'h04);
    end_frame();
    repeat (8) @(posedge clk);
    #1;
    checks++; if (mon_a_n - base !== 4) begin failures++; $display("FAIL good_count: got %0d expected 4", mon_a_n - base); end
    for (int k = 0; k < 4; k++) begin
      exp = {(k == 3), 8'(k + 1)};
      checks++; if (mon_a[base + k] !== exp) begin failures++; $display("FAIL good_byte%0d: got %0h expected %0h", k, mon_a[base + k], exp); end
    end
    checks++; if (len_a_n - lbase !== 1) begin failures++; $display("FAIL good_len_pulses: got %0d expected 1", len_a_n - lbase); end
    checks++; if (last_len_a !== 11'd4) begin failures++; $display("FAIL good_frame_len: got %0d expected 4", last_len_a); end
    checks++; if (bus_a.o_frame_cnt !== 8'd1) begin failures++; $display("FAIL good_frame_cnt: got %0d expected 1", bus_a.o_frame_cnt); end
    checks++; if (bus_a.o_err_cnt !== 8'd0) begin failures++; $display("FAIL good_err_cnt: got %0d expected 0", bus_a.o_err_cnt); end
  endtask

  task automatic test_bad_preamble();
    int base;
    do_reset();
    tb_ready = 1'b1;
    base = mon_a_n;
    send_byte(8'h55);
    send_byte(8'h55);
    send_byte(8'h33);
    send_byte(8'hD5);
    send_byte(8'h11);
    send_byte(8'h12);
    end_frame();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus_a.o_err_cnt !== 8'd1) begin failures++; $display("FAIL badpre_err_cnt: got %0d expected 1", bus_a.o_err_cnt); end
    checks++; if (mon_a_n - base !== 0) begin failures++; $display("FAIL badpre_no_output: got %0d expected 0", mon_a_n - base); end
    send_preamble(1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    end_frame();
    repeat (5) @(posedge clk);
    #1;
    checks++; if (mon_a_n - base !== 2) begin failures++; $display("FAIL badpre_next_count: got %0d expected 2", mon_a_n - base); end
    checks++; if (mon_a[base + 1] !== 9'h1BB) begin failures++; $display("FAIL badpre_next_last: got %0h expected 1bb", mon_a[base + 1]); end
    checks++; if (bus_a.o_frame_cnt !== 8'd1) begin failures++; $display("FAIL badpre_frame_cnt: got %0d expected 1", bus_a.o_frame_cnt); end
  endtask

  task automatic test_overflow();
    int base;
    int lbase;
    int budget;
    logic [8:0] exp;
    do_reset();
    tb_ready = 1'b0;
    base  = mon_a_n;
    lbase = len_a_n;
    send_preamble(7);
    for (int i = 0; i < 20; i++) send_byte(8'(8'h10 + i));
    end_frame();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus_a.o_overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %0h expected 1", bus_a.o_overflow); end
    checks++; if (bus_a.o_err_cnt !== 8'd1) begin failures++; $display("FAIL ovf_err_cnt: got %0d expected 1", bus_a.o_err_cnt); end
    checks++; if (bus_a.o_frame_cnt !== 8'd0) begin failures++; $display("FAIL ovf_frame_cnt: got %0d expected 0", bus_a.o_frame_cnt); end
    checks++; if (len_a_n - lbase !== 0) begin failures++; $display("FAIL ovf_len_pulses: got %0d expected 0", len_a_n - lbase); end
    checks++; if ({bus_a.o_out_valid, bus_a.o_out_last, bus_a.o_out_data} !== 10'h210) begin failures++; $display("FAIL ovf_hold_head: got %0h expected 210", {bus_a.o_out_valid, bus_a.o_out_last, bus_a.o_out_data}); end
    tb_ready = 1'b1;
    budget = 0;
    while (bus_a.o_out_valid === 1'b1 && budget < 60) begin
      @(posedge clk);
      #1;
      budget++;
    end
    checks++; if (bus_a.o_out_valid !== 1'b0) begin failures++; $display("FAIL ovf_drain_timeout: got %0h expected 0", bus_a.o_out_valid); end
    checks++; if (mon_a_n - base !== 16) begin failures++; $display("FAIL ovf_drain_count: got %0d expected 16", mon_a_n - base); end
    for (int k = 0; k < 16; k++) begin
      exp = {1'b0, 8'(8'h10 + k)};
      checks++; if (mon_a[base + k] !== exp) begin failures++; $display("FAIL ovf_byte%0d: got %0h expected %0h", k, mon_a[base + k], exp); end
    end
    checks++; if (bus_a.o_overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %0h expected 1", bus_a.o_overflow); end
  endtask

  task automatic test_oversize();
    int base;
    int lbase;
    logic [8:0] exp;
    do_reset();
    tb_ready = 1'b1;
    base  = mon_b_n;
    lbase = len_b_n;
    send_preamble(7);
    for (int i = 0; i < 10; i++) send_byte(8'(8'h21 + i));
    end_frame();
    repeat (12) @(posedge clk);
    #1;
    checks++; if (mon_b_n - base !== 8) begin failures++; $display("FAIL oversize_count: got %0d expected 8", mon_b_n - base); end
    for (int k = 0; k < 8; k++) begin
      exp = {(k == 7), 8'(8'h21 + k)};
      checks++; if (mon_b[base + k] !== exp) begin failures++; $display("FAIL oversize_byte%0d: got %0h expected %0h", k, mon_b[base + k], exp); end
    end
    checks++; if (bus_b.o_err_cnt !== 8'd1) begin failures++; $display("FAIL oversize_err_cnt: got %0d expected 1", bus_b.o_err_cnt); end
    checks++; if (bus_b.o_frame_cnt !== 8'd0) begin failures++; $display("FAIL oversize_frame_cnt: got %0d expected 0", bus_b.o_frame_cnt); end
    checks++; if (len_b_n - lbase !== 0) begin failures++; $display("FAIL oversize_len_pulses: got %0d expected 0", len_b_n - lbase); end
  endtask

  task automatic test_empty_and_saturation();
    int base;
    int lbase;
    do_reset();
    tb_ready = 1'b1;
    base  = mon_a_n;
    lbase = len_a_n;
    send_preamble(2);
    end_frame();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus_a.o_err_cnt !== 8'd1) begin failures++; $display("FAIL empty_err_cnt: got %0d expected 1", bus_a.o_err_cnt); end
    checks++; if (mon_a_n - base !== 0) begin failures++; $display("FAIL empty_no_output: got %0d expected 0", mon_a_n - base); end
    checks++; if (len_a_n - lbase !== 0) begin failures++; $display("FAIL empty_len_pulses: got %0d expected 0", len_a_n - lbase); end
    for (int f = 0; f < 260; f++) begin
      send_preamble(1);
      send_byte(8'(f));
      end_frame();
    end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus_a.o_frame_cnt !== 8'd255) begin failures++; $display("FAIL sat_frame_cnt: got %0d expected 255", bus_a.o_frame_cnt); end
    checks++; if (last_len_a !== 11'd1) begin failures++; $display("FAIL sat_frame_len: got %0d expected 1", last_len_a); end
    for (int f = 0; f < 260; f++) begin
      send_preamble(1);
      end_frame();
    end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus_a.o_err_cnt !== 8'd255) begin failures++; $display("FAIL sat_err_cnt: got %0d expected 255", bus_a.o_err_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    do_reset();
    tb_ready = 1'b1;
    send_preamble(7);
    send_byte(8'h0A);
    end_frame();
    repeat (3) @(posedge clk);
    #1;
    send_preamble(7);
    send_byte(8'h31);
    send_byte(8'h32);
    send_byte(8'h33);
    rst_n = 1'b0;
    #1;
    checks++; if (bus_a.o_out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid: got %0h expected 0", bus_a.o_out_valid); end
    checks++; if (bus_a.o_out_data !== 8'h00) begin failures++; $display("FAIL midrst_out_data: got %0h expected 0", bus_a.o_out_data); end
    checks++; if (bus_a.o_frame_cnt !== 8'd0) begin failures++; $display("FAIL midrst_frame_cnt: got %0d expected 0", bus_a.o_frame_cnt); end
    checks++; if (bus_a.o_frame_len !== 11'd0) begin failures++; $display("FAIL midrst_frame_len: got %0d expected 0", bus_a.o_frame_len); end
    tb_rx_dv = 1'b0;
    tb_rxd   = 8'h00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    base = mon_a_n;
    send_preamble(7);
    send_byte(8'h41);
    send_byte(8'h42);
    send_byte(8'h43);
    end_frame();
    repeat (6) @(posedge clk);
    #1;
    checks++; if (mon_a_n - base !== 3) begin failures++; $display("FAIL midrst_count: got %0d expected 3", mon_a_n - base); end
    checks++; if (mon_a[base] !== 9'h041) begin failures++; $display("FAIL midrst_first: got %0h expected 041", mon_a[base]); end
    checks++; if (mon_a[base + 2] !== 9'h143) begin failures++; $display("FAIL midrst_last: got %0h expected 143", mon_a[base + 2]); end
    checks++; if (last_len_a !== 11'd3) begin failures++; $display("FAIL midrst_frame_len: got %0d expected 3", last_len_a); end
    checks++; if (bus_a.o_frame_cnt !== 8'd1) begin failures++; $display("FAIL midrst_frame_cnt: got %0d expected 1", bus_a.o_frame_cnt); end
    checks++; if (bus_a.o_err_cnt !== 8'd0) begin failures++; $display("FAIL midrst_err_cnt: got %0d expected 0", bus_a.o_err_cnt); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    tb_rxd   = 8'h00;
    tb_rx_dv = 1'b0;
    tb_ready = 1'b1;
    test_reset();
    test_good_frame();
    test_bad_preamble();
    test_overflow();
    test_oversize();
    test_empty_and_saturation();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
